// File: rtl/i8088_bus_slave_if.sv
// 8088 minimum-mode bus pins shared by every slave on the bus.
// AD and READY are shared tri-state lines; they float high when nobody drives them.
interface i8088_bus_slave_if;
  logic        ALE;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic        DEN;
  logic        DTR;
  logic [11:0] A;
  tri1  [7:0]  AD;
  tri1         READY;

  modport master (
    output ALE, IOM, RD, WR, DEN, DTR, A,
    inout  AD,
    inout  READY
  );

  modport slave (
    input  ALE, IOM, RD, WR, DEN, DTR, A,
    inout  AD,
    inout  READY
  );
endinterface

// File: rtl/i8088_bus_slave.sv
// Address-decoded 8088 byte memory/I-O target with programmable READY wait states.
// Optional transfer counters are built when I8088_SLAVE_STATS_EN is defined.
module i8088_bus_slave #(
  parameter logic [19:0] ADDR_BASE   = 20'h00000,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter bit          IS_IO       = 1'b0,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  i8088_bus_slave_if.slave       bus,
  output logic                   ERR
`ifdef I8088_SLAVE_STATS_EN
  ,
  output logic [15:0]            RD_COUNT,
  output logic [15:0]            WR_COUNT
`endif
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [19:0] MEM_MASK = 20'hFFFFF << ADDR_WIDTH;
  localparam logic [19:0] DEC_MASK = IS_IO ? (MEM_MASK & 20'h0FFFF) : MEM_MASK;
  localparam logic [3:0]  WS       = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [19:0]             addr_q;
  logic                    iom_q;
  logic                    err_q;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    err_set;
  logic                    do_write;
  logic                    rd_done;
  logic                    sel;
  logic                    ad_oe;
  logic                    rd_low, wr_low;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [7:0]              mem [DEPTH];

  assign rd_low = ~bus.RD;
  assign wr_low = ~bus.WR;
  assign offset = addr_q[ADDR_WIDTH-1:0];

  // Only the bits above the window take part; I/O space ignores 19:16.
  assign sel = (iom_q == IS_IO) && (((addr_q ^ ADDR_BASE) & DEC_MASK) == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      iom_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (bus.ALE) begin
        addr_q <= {bus.A, bus.AD};
        iom_q  <= bus.IOM;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    err_set  = 1'b0;
    do_write = 1'b0;
    rd_done  = 1'b0;
    if (bus.ALE) begin
      // A new address phase aborts whatever cycle was in flight.
      state_d = S_ADDR;
      cnt_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (sel) begin
            if (rd_low && wr_low) begin
              err_set = 1'b1;
              rd_d    = 1'b0;
              wr_d    = 1'b0;
              state_d = S_DONE;
            end else if (rd_low || wr_low) begin
              rd_d = rd_low;
              wr_d = wr_low;
              if (WS != 4'd0) begin
                cnt_d   = WS;
                state_d = S_WAIT;
              end else begin
                state_d = S_XFER;
              end
            end
          end
        end
        S_WAIT: begin
          if (!rd_low && !wr_low) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = S_XFER;
            end
          end
        end
        S_XFER: begin
          do_write = wr_q;
          rd_done  = rd_q;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (!rd_low && !wr_low) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[offset] <= bus.AD;
    end
  end

  // Combinational enable so AD lets go in the same cycle RD or DEN rises.
  assign ad_oe = sel && rd_q && ((state_q == S_XFER) || (state_q == S_DONE)) &&
                 !bus.RD && !bus.DEN && !bus.DTR;

  assign bus.AD    = ad_oe ? mem[offset] : 'z;
  assign bus.READY = (state_q == S_WAIT) ? 1'b0 : 1'bz;
  assign ERR       = err_q;

`ifdef I8088_SLAVE_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RD_COUNT <= '0;
      WR_COUNT <= '0;
    end else begin
      if (rd_done) begin
        RD_COUNT <= RD_COUNT + 16'd1;
      end
      if (do_write) begin
        WR_COUNT <= WR_COUNT + 16'd1;
      end
    end
  end
`endif

endmodule
